ans_ram_read_ctrl: RTL and testbench

- Reader for the pooled-result RAM filled by the result write controller. After the pooling pass completes, it walks the answer RAM in row-major order.
- Streams each 8-bit result out on a valid/ready interface, for a host or the next layer's input loader.
- Owns the RAM port for the whole readback and signals completion with a one-cycle done pulse.

---
 rtl/ans_ram_read_ctrl_if.sv | 23 ++
 rtl/ans_ram_read_ctrl.sv | 156 +++++++++++++++
 tb/tb_ans_ram_read_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ans_ram_read_ctrl_if.sv
// RAM port and result stream shared by the answer-RAM reader and its neighbours.
// The master side is the reader: it drives the RAM request and the stream beat.
interface ans_ram_read_ctrl_if;
    logic        ram_en;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wr;
    logic [7:0]  ram_rd;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        last;

    // Stream: a beat moves on every cycle with valid & ready; once valid rises, data and last hold until that beat.
    modport master (
        output ram_en, ram_addr, ram_we, ram_wr, data, valid, last,
        input  ram_rd, ready
    );
    modport slave (
        input  ram_en, ram_addr, ram_we, ram_wr, data, valid, last,
        output ram_rd, ready
    );
endinterface

// File: rtl/ans_ram_read_ctrl.sv
// Streams the pooled result map (OH*OW bytes at BASE) out of the answer RAM in row-major order.
// Define ANS_RD_CLEAR_EN to zero the map after readback, ready for the next frame.
module ans_ram_read_ctrl #(
    parameter int unsigned H    = 6,
    parameter int unsigned W    = 6,
    parameter logic [31:0] BASE = 32'd0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [2:0]          dbg_state,
    ans_ram_read_ctrl_if.master bus
);
    localparam logic [31:0] N        = 32'((H / 2) * (W / 2));
    localparam logic [31:0] LAST_IDX = N - 32'd1;
    localparam bit          HAS_DATA = (N != 32'd0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_DRAIN  = 3'd2,
        S_FINISH = 3'd3
`ifdef ANS_RD_CLEAR_EN
        , S_CLEAR = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] issue_idx_q, issue_idx_d;
    logic [31:0] out_idx_q, out_idx_d;
    logic        inflight_q, inflight_d;
    logic [7:0]  fifo_q [2];
    logic [7:0]  fifo_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        fifo_valid, pop, issue, clearing;
    logic [2:0]  occupancy;
    logic [31:0] clr_idx;

`ifdef ANS_RD_CLEAR_EN
    logic [31:0] clr_idx_q, clr_idx_d;
    assign clearing = (state_q == S_CLEAR);
    assign clr_idx  = clr_idx_q;
`else
    assign clearing = 1'b0;
    assign clr_idx  = 32'd0;
`endif

    // Occupancy counts the beat leaving this cycle as gone, so a full-rate stream keeps one read in flight.
    always_comb begin
        fifo_valid = (count_q != 2'd0);
        pop        = fifo_valid & bus.ready;
        occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = (state_q == S_READ) && HAS_DATA && (occupancy < 3'd2);
    end

    assign bus.valid    = fifo_valid;
    assign bus.data     = fifo_valid ? fifo_q[rd_ptr_q] : 8'd0;
    assign bus.last     = fifo_valid && (out_idx_q == LAST_IDX);
    assign bus.ram_en   = issue | clearing;
    assign bus.ram_we   = clearing;
    assign bus.ram_wr   = 8'd0;
    assign bus.ram_addr = issue    ? BASE + issue_idx_q :
                          clearing ? BASE + clr_idx     : 32'd0;
    assign busy         = (state_q == S_READ) || (state_q == S_DRAIN) || clearing;
    assign done         = (state_q == S_FINISH);
    assign dbg_state    = state_q;

    always_comb begin
        state_d     = state_q;
        issue_idx_d = issue_idx_q + {31'd0, issue};
        out_idx_d   = out_idx_q + {31'd0, pop};
        inflight_d  = issue;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q ^ inflight_q;
        rd_ptr_d    = rd_ptr_q ^ pop;
        count_d     = count_q + {1'b0, inflight_q} - {1'b0, pop};
        if (inflight_q) begin
            fifo_d[wr_ptr_q] = bus.ram_rd;
        end
`ifdef ANS_RD_CLEAR_EN
        clr_idx_d = clr_idx_q + {31'd0, clearing};
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_READ;
                    issue_idx_d = 32'd0;
                    out_idx_d   = 32'd0;
                    inflight_d  = 1'b0;
                    wr_ptr_d    = 1'b0;
                    rd_ptr_d    = 1'b0;
                    count_d     = 2'd0;
                end
            end
            S_READ: begin
                if (!HAS_DATA) begin
                    state_d = S_FINISH;
                end else if (issue && (issue_idx_q == LAST_IDX)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && bus.last) begin
`ifdef ANS_RD_CLEAR_EN
                    state_d   = S_CLEAR;
                    clr_idx_d = 32'd0;
`else
                    state_d = S_FINISH;
`endif
                end
            end
`ifdef ANS_RD_CLEAR_EN
            S_CLEAR: begin
                if (clr_idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end
            end
`endif
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            issue_idx_q <= 32'd0;
            out_idx_q   <= 32'd0;
            inflight_q  <= 1'b0;
            fifo_q[0]   <= 8'd0;
            fifo_q[1]   <= 8'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
`ifdef ANS_RD_CLEAR_EN
            clr_idx_q   <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            issue_idx_q <= issue_idx_d;
            out_idx_q   <= out_idx_d;
            inflight_q  <= inflight_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
`ifdef ANS_RD_CLEAR_EN
            clr_idx_q   <= clr_idx_d;
`endif
        end
    end
endmodule

// File: tb/tb_ans_ram_read_ctrl.sv
// Bench for ans_ram_read_ctrl: a 6x6 map driven through a table of ready patterns and
// corner cases, plus 1x1 (empty map) and 2x3 at BASE=100 (single element) instances.
module tb_ans_ram_read_ctrl;
    localparam int N0 = 9;
`ifdef ANS_RD_CLEAR_EN
    localparam int CLR_N = 9;
`else
    localparam int CLR_N = 0;
`endif

    logic       clk;
    logic       rstn;
    logic       start0, start1, start2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [2:0] dbg0, dbg1, dbg2;

    ans_ram_read_ctrl_if bus0 ();
    ans_ram_read_ctrl_if bus1 ();
    ans_ram_read_ctrl_if bus2 ();

    ans_ram_read_ctrl #(.H(6), .W(6), .BASE(32'd0)) dut0 (
        .clk(clk), .rstn(rstn), .start(start0), .busy(busy0), .done(done0),
        .dbg_state(dbg0), .bus(bus0)
    );
    ans_ram_read_ctrl #(.H(1), .W(1), .BASE(32'd0)) dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .busy(busy1), .done(done1),
        .dbg_state(dbg1), .bus(bus1)
    );
    ans_ram_read_ctrl #(.H(2), .W(3), .BASE(32'd100)) dut2 (
        .clk(clk), .rstn(rstn), .start(start2), .busy(busy2), .done(done2),
        .dbg_state(dbg2), .bus(bus2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM models ----------------
    logic [7:0] ram0 [256];
    logic [7:0] gold [N0];

    always @(posedge clk) begin
        if (bus0.ram_en && !bus0.ram_we && bus0.ram_addr < 32'd256)
            bus0.ram_rd <= ram0[bus0.ram_addr[7:0]];
    end
    assign bus1.ram_rd = 8'h00;
    always @(posedge clk) begin
        if (bus2.ram_en && !bus2.ram_we)
            bus2.ram_rd <= (bus2.ram_addr == 32'd100) ? 8'h5A : 8'hEE;
    end

    // ---------------- scoreboard ----------------
    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q [$];

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_idle0(input string name);
        logic [63:0] v;
        v = {10'd0, bus0.ram_en, bus0.ram_we, bus0.ram_wr, bus0.ram_addr, bus0.data,
             bus0.valid, bus0.last, busy0, done0};
        check(v == 64'd0, name, longint'(v), 0);
    endtask

    function automatic logic pick_ready(input int mode, input int s);
        case (mode)
            0:       return 1'b1;
            1:       return (s % 3 == 1);
            2:       return 1'($urandom_range(0, 1));
            default: return (s > 8);
        endcase
    endfunction

    // ---------------- driver / monitor for the 6x6 instance ----------------
    task automatic run_read(input int mode, input int start_at, input int rst_after,
                            input int exp_first, input int exp_done);
        int         acc, issued, wr_cnt, first, done_step, rst_state;
        bit         finished, stall, pop_now;
        logic [7:0] hold, exp;
        acc = 0; issued = 0; wr_cnt = 0; first = -1; done_step = -1; rst_state = 0;
        finished = 0; stall = 0; hold = 8'd0;
        exp_q.delete();
        for (int i = 0; i < N0; i++) exp_q.push_back(gold[i]);

        @(posedge clk); #1;
        start0 = 1'b1;
        for (int s = 1; s <= 300 && !finished; s++) begin
            @(posedge clk); #1;
            start0 = (s == start_at);
            bus0.ready = pick_ready(mode, s);
            if (rst_state == 1) begin
                rstn = 1'b0;
                rst_state = 2;
            end else if (rst_state == 2) begin
                rst_state = 3;
            end
            @(negedge clk);
            if (rst_state == 3) begin
                check_idle0("reset_mid_stream");
                finished = 1;
            end else begin
                pop_now = bus0.valid && bus0.ready;
                if (bus0.ram_en && !bus0.ram_we) begin
                    check(bus0.ram_addr == 32'(issued), "rd_addr", longint'(bus0.ram_addr), issued);
                    check(issued + 1 - acc - int'(pop_now) <= 2, "rd_ahead",
                          issued + 1 - acc - int'(pop_now), 2);
                    issued++;
                end
                if (bus0.ram_en && bus0.ram_we) begin
                    check(bus0.ram_addr == 32'(wr_cnt) && bus0.ram_wr == 8'd0, "clr_write",
                          longint'(bus0.ram_addr), wr_cnt);
                    if (bus0.ram_addr < 32'd256) ram0[bus0.ram_addr[7:0]] = bus0.ram_wr;
                    wr_cnt++;
                end
                if (stall) check(bus0.valid && bus0.data == hold, "stall_hold", bus0.data, hold);
                if (bus0.valid && first < 0) first = s - 1;
                if (pop_now) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "extra_elem", bus0.data, 0);
                    end else begin
                        exp = exp_q.pop_front();
                        check(bus0.data == exp, "data", bus0.data, exp);
                        check(bus0.last == (exp_q.size() == 0), "last", bus0.last, exp_q.size() == 0);
                    end
                    acc++;
                    if (rst_after > 0 && acc == rst_after) rst_state = 1;
                end
                stall = bus0.valid && !bus0.ready;
                hold  = bus0.data;
                check(busy0 == !done0, "busy", busy0, !done0);
                if (done0) begin
                    done_step = s - 1;
                    finished  = 1;
                end
            end
        end

        if (!finished) begin
            check(1'b0, "timeout", 0, 1);
        end else if (rst_after == 0) begin
            check(acc == N0, "elem_count", acc, N0);
            check(issued == N0, "read_count", issued, N0);
            check(wr_cnt == CLR_N, "clear_writes", wr_cnt, CLR_N);
            check(first == exp_first, "first_valid_lat", first, exp_first);
            if (exp_done >= 0) check(done_step == exp_done, "done_lat", done_step, exp_done);
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        rstn   = 1'b1;
        @(negedge clk);
        check(!busy0 && !done0 && !bus0.valid, "after_done", {busy0, done0, bus0.valid}, 0);
    endtask

    // ---------------- empty map and single-element map ----------------
    task automatic run_small;
        int rd1, v1, d1, rd2, v2, d2;
        rd1 = 0; v1 = 0; d1 = 0; rd2 = 0; v2 = 0; d2 = 0;
        @(posedge clk); #1;
        start1 = 1'b1; start2 = 1'b1; bus1.ready = 1'b1; bus2.ready = 1'b1;
        for (int s = 1; s <= 30; s++) begin
            @(posedge clk); #1;
            start1 = 1'b0; start2 = 1'b0;
            @(negedge clk);
            if (bus1.ram_en) rd1++;
            if (bus1.valid) v1++;
            if (done1) d1++;
            if (bus2.ram_en && !bus2.ram_we) begin
                rd2++;
                check(bus2.ram_addr == 32'd100, "n1_addr", longint'(bus2.ram_addr), 100);
            end
            if (bus2.valid && bus2.ready) begin
                v2++;
                check(bus2.data == 8'h5A, "n1_data", bus2.data, 8'h5A);
                check(bus2.last, "n1_last", bus2.last, 1);
            end
            if (done2) d2++;
        end
        check(rd1 == 0, "n0_ram_en", rd1, 0);
        check(v1 == 0, "n0_valid", v1, 0);
        check(d1 == 1, "n0_done", d1, 1);
        check(rd2 == 1, "n1_reads", rd2, 1);
        check(v2 == 1, "n1_elems", v2, 1);
        check(d2 == 1, "n1_done", d2, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int mode;       // 0 always ready, 1 pattern 1,0,0, 2 random, 3 stalled for 8 cycles
        int start_at;   // extra start pulse at this step (0 = none)
        int rst_after;  // reset after this many transfers (0 = none)
        bit rand_data;
        int exp_first;  // edges from start edge to first valid
        int exp_done;   // edges from start edge to done (-1 = unchecked)
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        vecs[0] = '{0, 0,          0, 1'b0, 2, 11 + CLR_N};
        vecs[1] = '{1, 0,          0, 1'b0, 2, -1};
        vecs[2] = '{0, 5,          0, 1'b0, 2, 11 + CLR_N};
        vecs[3] = '{0, 0,          4, 1'b0, 2, -1};
        vecs[4] = '{0, 0,          0, 1'b0, 2, 11 + CLR_N};
        vecs[5] = '{2, 0,          0, 1'b1, 2, -1};
        vecs[6] = '{3, 0,          0, 1'b1, 2, -1};
        vecs[7] = '{0, 12 + CLR_N, 0, 1'b1, 2, 11 + CLR_N};
        vecs[8] = '{2, 3,          0, 1'b1, 2, -1};

        rstn = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        bus0.ready = 1'b0; bus1.ready = 1'b0; bus2.ready = 1'b0;
        for (int i = 0; i < 256; i++) ram0[i] = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle0("reset_state");
        check(!busy1 && !done1 && !bus1.valid && !busy2 && !done2 && !bus2.valid,
              "reset_small", {busy1, done1, bus1.valid, busy2, done2, bus2.valid}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < N0; i++) begin
                gold[i] = vecs[v].rand_data ? 8'($urandom_range(0, 255)) : 8'(10 + i);
                ram0[i] = gold[i];
            end
            run_read(vecs[v].mode, vecs[v].start_at, vecs[v].rst_after,
                     vecs[v].exp_first, vecs[v].exp_done);
        end

`ifdef ANS_RD_CLEAR_EN
        for (int i = 0; i < N0; i++) gold[i] = 8'd0;
        run_read(0, 0, 0, 2, 11 + CLR_N);
`endif

        run_small();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
